pipeline_hazard_ctrl: RTL

Central stall/flush controller for the scalar/vector image-filter pipeline. It drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, resolving three things: load-use hazards, multi-cycle data-memory accesses and taken-branch squashes. It also keeps a saturating stall counter for profiling.

---
 rtl/pipeline_hazard_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the filter pipeline: load-use bubbles, multi-cycle
// data-memory freezes, taken-branch squashes and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int MEM_WAIT = 2,
    parameter int REG_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_we,
    input  logic             mem_req,
    input  logic             branch_taken,
    input  logic             halt,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       state,
    output logic [15:0]      stall_count
);

    localparam int CNT_W = $clog2(MEM_WAIT + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        MEMW   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             served_q, served_d;
    logic [15:0]      stall_q, stall_d;
    logic             stall_inc;
    logic             load_use;

    always_comb begin
        load_use = ex_is_load & ex_we &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        served_d    = served_q;
        stall_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (mem_req && !served_q && (MEM_WAIT > 0)) begin
                    stall_inc = 1'b1;
                    if (MEM_WAIT == 1) begin
                        served_d = 1'b1;
                    end else begin
                        state_d = MEMW;
                        cnt_d   = CNT_W'(MEM_WAIT - 1);
                    end
                end else begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                    // The access in MEM has moved on, so the next one must freeze again.
                    served_d  = 1'b0;
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end
                end
            end
            MEMW: begin
                stall_inc = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = RUN;
                    served_d = 1'b1;
                end
            end
            HALTED: begin
            end
        endcase

        stall_d = (stall_inc && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            served_q <= 1'b0;
            stall_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            served_q <= served_d;
            stall_q  <= stall_d;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_q;

endmodule
